// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert one even-parity bit after the data MSB.
module uart_tx #(
  parameter int unsigned DataBits = 8,
  parameter int unsigned StopBits = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [15:0]         i_scaler,
  input  logic [DataBits-1:0] i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic                o_tx,
  output logic                o_busy,
  output logic                o_done
);

  localparam int unsigned IdxW = $clog2(DataBits);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e              state_q;
  logic [15:0]         scale_q;
  logic [15:0]         cnt_q;
  logic [IdxW-1:0]     idx_q;
  logic [DataBits-1:0] shift_q;
  logic                tx_q;
  logic                busy_q;
  logic                done_q;
`ifdef UART_TX_PARITY_EN
  logic                par_q;
`endif

  // Compare before increment so scale_q = 16'hFFFF never overflows the counter.
  logic bit_end;
  assign bit_end = (cnt_q == scale_q);

  assign o_ready = (state_q == StIdle) && i_en && i_rst_n;
  assign o_tx    = tx_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      scale_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (!i_en) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            shift_q <= i_data;
            scale_q <= i_scaler;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StStart;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^i_data;
`endif
          end
        end
        StStart: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q   <= '0;
            shift_q <= shift_q >> 1;
            if (idx_q == IdxW'(DataBits - 1)) begin
              idx_q <= '0;
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= StParity;
`else
              tx_q    <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
              tx_q  <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`endif
        StStop: begin
          if (bit_end) begin
            cnt_q <= '0;
            // idx_q doubles as the stop-bit counter.
            if (idx_q == IdxW'(StopBits - 1)) begin
              idx_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: the driver queues accepted frames, the monitor
// rebuilds each frame's line waveform from the data and scaler and compares it.
module tb_uart_tx;

  localparam int unsigned DataBits = 8;
  localparam int unsigned StopBits = 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned ParBits = 1;
`else
  localparam int unsigned ParBits = 0;
`endif

  typedef struct {
    logic [7:0] data;
    int         scale;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] scaler;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        tx;
  logic        busy;
  logic        done;

  int     n_tests = 0;
  int     n_fail  = 0;
  frame_t exp_q[$];

  uart_tx #(
    .DataBits (DataBits),
    .StopBits (StopBits)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_en     (en),
    .i_scaler (scaler),
    .i_data   (data),
    .i_valid  (valid),
    .o_ready  (ready),
    .o_tx     (tx),
    .o_busy   (busy),
    .o_done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a frame and wait for the accepting edge; i_valid is left high.
  task automatic send(input logic [7:0] d, input int sc);
    int waited = 0;
    @(negedge clk);
    data   = d;
    scaler = 16'(sc);
    valid  = 1'b1;
    while (!ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      check("ready_timeout", 32'(ready), 32'd1);
    end else begin
      exp_q.push_back('{data: d, scale: sc});
      @(posedge clk);
    end
  endtask

  task automatic drop_valid();
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited = 0;
    @(negedge clk);
    while (busy && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Monitor: capture the line while busy, score the frame on each done pulse.
  initial begin
    bit     cap[$];
    bit     bits[$];
    frame_t f;
    bit     prev_done = 1'b0;
    bit     gap_chk   = 1'b0;
    int     bad;
    int     per;
    forever begin
      @(negedge clk);
      if (gap_chk) begin
        check("b2b_no_gap", {30'd0, busy, tx}, 32'b10);
        check("b2b_ready_one_cycle", 32'(ready), 32'd0);
        gap_chk = 1'b0;
      end
      if (done === 1'b1) begin
        check("done_single_pulse", 32'(prev_done), 32'd0);
        check("ready_with_done", 32'(ready), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          f = exp_q.pop_front();
          per = f.scale + 1;
          bits.delete();
          bits.push_back(1'b0);
          for (int i = 0; i < DataBits; i++) bits.push_back(f.data[i]);
          if (ParBits == 1) bits.push_back(^f.data);
          for (int i = 0; i < StopBits; i++) bits.push_back(1'b1);
          check($sformatf("frame_%02h_len", f.data), 32'(cap.size()), 32'(bits.size() * per));
          bad = 0;
          for (int j = 0; j < cap.size() && j < bits.size() * per; j++)
            if (cap[j] != bits[j / per]) bad++;
          check($sformatf("frame_%02h_bits_wrong", f.data), 32'(bad), 32'd0);
        end
        if (valid && en) gap_chk = 1'b1;
        cap.delete();
      end
      prev_done = (done === 1'b1);
      if (busy === 1'b1) cap.push_back(tx);
      else cap.delete();
    end
  end

  initial begin
    logic [7:0] d;
    rst_n  = 1'b0;
    en     = 1'b1;
    scaler = 16'd0;
    data   = 8'd0;
    valid  = 1'b0;
    #12;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_rst", 32'(ready), 32'd1);

    // Single frame, 4 cycles per bit.
    send(8'hA5, 3);
    drop_valid();
    wait_idle();

    // Back-to-back with i_valid held high.
    send(8'h00, 0);
    send(8'hFF, 0);
    drop_valid();
    wait_idle();

    // Minimum scaler.
    send(8'h3C, 0);
    drop_valid();
    wait_idle();

    // Abort during data bit 2 (cycles 24..31 after accept).
    send(8'hFF, 7);
    exp_q.pop_back();
    drop_valid();
    repeat (24) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (5) begin
      @(negedge clk);
      valid = 1'b1;
      check("abort_ready_low", 32'(ready), 32'd0);
      check("abort_no_done", 32'(done), 32'd0);
    end
    valid = 1'b0;
    en = 1'b1;
    send(8'h81, 7);
    drop_valid();
    wait_idle();

    // Asynchronous reset mid-frame.
    send(8'h55, 3);
    exp_q.pop_back();
    drop_valid();
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scaler is latched at accept.
    send(8'h5A, 3);
    drop_valid();
    repeat (6) @(negedge clk);
    scaler = 16'd9;
    wait_idle();

    // Parity vectors (plain frames when parity is compiled out).
    send(8'h07, 1);
    drop_valid();
    wait_idle();
    send(8'h03, 1);
    drop_valid();
    wait_idle();

    // Randomized frames with random gaps or back-to-back.
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      send(d, int'($urandom_range(0, 4)));
      if ($urandom_range(0, 2) != 0) begin
        drop_valid();
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
    end
    drop_valid();
    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
